fifo_playback: RTL and testbench

- Read-side sequencer for the 4-bit board FIFO, running on the 100 MHz board clock.
- When enabled, it pops one word at a time from a FIFO with registered read data and presents each word on data_out for a fixed hold time.
- It counts the words popped, so stored data can be replayed onto LEDs or a display at a human-visible rate.
- It is the consumer/reader counterpart to the switch-and-button write path.

---
 rtl/fifo_playback.sv | 101 ++++++++++
 tb/tb_fifo_playback.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fifo_playback.sv
// Read-side sequencer for the board FIFO: pops one word at a time, holds it on
// data_out for HOLD_CYCLES clocks and counts the words popped.
module fifo_playback #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 8
) (
  input  logic             clk100MHz,
  input  logic             reset,
  input  logic             run,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [CNT_W-1:0] pop_count
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  pop_q, pop_d;
  logic              start_read;
  logic              hold_done;

  assign start_read = run && !fifo_empty;
  assign hold_done  = (hold_q == '0);

  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_read) state_d = READ;
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = HOLD;
      HOLD:    if (hold_done) state_d = start_read ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data arrives the cycle after the strobe, so capture happens in CAPTURE.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    pop_d   = pop_q;
    hold_d  = hold_q;
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: valid_d = 1'b0;
      CAPTURE: begin
        data_d  = fifo_rd_data;
        pop_d   = pop_q + CNT_W'(1);
        hold_d  = HOLD_LOAD;
        valid_d = 1'b1;
      end
      HOLD: begin
        if (hold_done) valid_d = 1'b0;
        else           hold_d  = hold_q - HOLD_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk100MHz) begin
    if (reset) begin
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      pop_q   <= '0;
    end else begin
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      pop_q   <= pop_d;
    end
  end

  assign fifo_rd_en = (state_q == READ);
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign pop_count  = pop_q;

endmodule

// File: tb/tb_fifo_playback.sv
// Randomized bench for fifo_playback: a queue-based FIFO feeds the DUT and a
// timeline model (cycle of each read strobe) predicts every output.
module tb_fifo_playback;

  localparam int WIDTH = 4;
  localparam int H     = 4;
  localparam int CNT_W = 2;
  localparam int NCYC  = 3000;

  logic             clk100MHz = 1'b0;
  logic             reset;
  logic             run;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic [CNT_W-1:0] pop_count;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [WIDTH-1:0] fifo_q[$];

  bit               have_rd;
  int               last_rd;
  logic [WIDTH-1:0] exp_word;
  logic [WIDTH-1:0] exp_data;
  int               exp_pop;
  bit               exp_rd_en;
  bit               rst_pend;
  bit               exp_valid;
  bit               exp_busy;

  fifo_playback #(.WIDTH(WIDTH), .HOLD_CYCLES(H), .CNT_W(CNT_W)) dut (
    .clk100MHz   (clk100MHz),
    .reset       (reset),
    .run         (run),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .pop_count   (pop_count)
  );

  always #5 clk100MHz = ~clk100MHz;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Traffic mix rotates every 250 cycles: moderate, starved, and saturated FIFO.
  task automatic applyStimulus(input int c);
    int phase;
    int push_pct;
    int toggle_pct;
    phase = (c / 250) % 3;
    push_pct   = (phase == 0) ? 30 : (phase == 1) ? 5 : 60;
    toggle_pct = (phase == 2) ? 1 : 5;
    reset = (c < 2) ? 1'b1 : ($urandom_range(0, 79) == 0);
    if ($urandom_range(0, 99) < toggle_pct) run = ~run;
    if (($urandom_range(0, 99) < push_pct) && (fifo_q.size() < 12))
      fifo_q.push_back(WIDTH'($urandom_range(0, 15)));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  initial begin
    reset        = 1'b1;
    run          = 1'b1;
    fifo_rd_data = '0;
    fifo_q.push_back(4'hA);
    fifo_empty   = 1'b0;
    have_rd      = 1'b0;
    last_rd      = 0;
    exp_word     = '0;
    exp_data     = '0;
    exp_pop      = 0;
    exp_rd_en    = 1'b0;
    rst_pend     = 1'b1;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk100MHz);
      if (rst_pend) begin
        have_rd  = 1'b0;
        exp_data = '0;
        exp_pop  = 0;
      end
      if (have_rd && c == last_rd + 2) begin
        exp_data = exp_word;
        exp_pop  = (exp_pop + 1) % (1 << CNT_W);
      end
      if (exp_rd_en) begin
        have_rd  = 1'b1;
        last_rd  = c;
        exp_word = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      end
      exp_valid = have_rd && (c >= last_rd + 2) && (c <= last_rd + H + 1);
      exp_busy  = have_rd && (c <= last_rd + H + 1);

      checkOutput("rd_en",      32'(fifo_rd_en), 32'(exp_rd_en));
      checkOutput("data_valid", 32'(data_valid), 32'(exp_valid));
      checkOutput("busy",       32'(busy),       32'(exp_busy));
      checkOutput("data_out",   32'(data_out),   32'(exp_data));
      checkOutput("pop_count",  32'(pop_count),  32'(exp_pop));

      if (fifo_rd_en === 1'b1 && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();

      applyStimulus(c);
      exp_rd_en = !reset && run && !fifo_empty && (!have_rd || c >= last_rd + H + 1);
      rst_pend  = reset;
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
